// File: rtl/alu_pkg.sv
// Shared constants and E-stage payload type for the ALU issue stage.
package alu_pkg;

    // ALU operation codes understood by the combinational ALU.
    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;
    localparam logic [3:0] ALU_NOR = 4'b1100;

    // Decoder aluop classes.
    localparam logic [1:0] ALUOP_MEM   = 2'b00;
    localparam logic [1:0] ALUOP_BR    = 2'b01;
    localparam logic [1:0] ALUOP_ARITH = 2'b10;
    localparam logic [1:0] ALUOP_RSV   = 2'b11;

    // Payload widths; the top-level XLEN/TAG_W parameters must match these.
    localparam int unsigned PKG_XLEN  = 64;
    localparam int unsigned PKG_TAG_W = 5;

    typedef struct packed {
        logic [PKG_XLEN-1:0]  src1;
        logic [PKG_XLEN-1:0]  src2;
        logic [3:0]           op_sel;
        logic [PKG_TAG_W-1:0] tag;
        logic                 illegal;
        logic                 branch;
    } e_payload_t;

endpackage

// File: rtl/alu_op_decode.sv
// Combinational ALU op_sel decoder.
// Optional macro ALU_ISSUE_NOR_EN: aluop=10, funct3=100, funct7b5=1 decodes to NOR
// instead of being flagged illegal.
module alu_op_decode
    import alu_pkg::*;
(
    input  logic [1:0] i_aluop,
    input  logic [2:0] i_funct3,
    input  logic       i_funct7b5,
    input  logic       i_use_imm,
    output logic [3:0] o_op_sel,
    output logic       o_illegal
);

    // Map decoded instruction fields onto an ALU operation; unknown encodings become illegal.
    always_comb begin
        o_op_sel  = ALU_AND;
        o_illegal = 1'b0;
        unique case (i_aluop)
            ALUOP_MEM: o_op_sel = ALU_ADD;
            ALUOP_BR:  o_op_sel = ALU_SUB;
            ALUOP_ARITH: begin
                case (i_funct3)
                    // ADDI has no SUB form, so bit 30 only matters for register ops.
                    3'b000:  o_op_sel = (i_funct7b5 && !i_use_imm) ? ALU_SUB : ALU_ADD;
                    3'b111:  o_op_sel = ALU_AND;
                    3'b110:  o_op_sel = ALU_OR;
                    3'b010:  o_op_sel = ALU_SLT;
`ifdef ALU_ISSUE_NOR_EN
                    3'b100: begin
                        if (i_funct7b5) begin
                            o_op_sel = ALU_NOR;
                        end else begin
                            o_illegal = 1'b1;
                        end
                    end
`endif
                    default: o_illegal = 1'b1;
                endcase
            end
            ALUOP_RSV: o_illegal = 1'b1;
            default:   o_illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/alu_issue_stage.sv
// Producer side of the 64-bit ALU interface: E stage drives registered operands and op_sel
// to the combinational ALU, W stage holds the result for a valid/ready consumer.
// Optional macro ALU_ISSUE_NOR_EN (handled in alu_op_decode) enables the NOR encoding.
module alu_issue_stage
    import alu_pkg::*;
#(
    parameter int unsigned XLEN  = 64,
    parameter int unsigned TAG_W = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_aluop,
    input  logic [2:0]       in_funct3,
    input  logic             in_funct7b5,
    input  logic             in_use_imm,
    input  logic [XLEN-1:0]  in_rs1,
    input  logic [XLEN-1:0]  in_rs2,
    input  logic [XLEN-1:0]  in_imm,
    input  logic [TAG_W-1:0] in_tag,
    output logic [XLEN-1:0]  alu_src1,
    output logic [XLEN-1:0]  alu_src2,
    output logic [3:0]       alu_op_sel,
    input  logic [XLEN-1:0]  alu_result,
    input  logic             alu_zero,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [XLEN-1:0]  res_data,
    output logic             res_zero,
    output logic [TAG_W-1:0] res_tag,
    output logic             res_illegal,
    output logic             res_branch
);

    // The E payload struct is sized by the package; reject mismatched parameters early.
    if (XLEN != PKG_XLEN || TAG_W != PKG_TAG_W) begin : g_width_check
        $error("alu_issue_stage: XLEN/TAG_W must match alu_pkg payload widths");
    end

    logic [3:0]  w_op_sel;
    logic        w_illegal;
    logic        w_free;
    logic        w_e_adv;
    logic        w_accept;
    e_payload_t  w_e_next;

    e_payload_t       r_e;
    logic             r_e_valid;
    logic             r_res_valid;
    logic [XLEN-1:0]  r_res_data;
    logic             r_res_zero;
    logic [TAG_W-1:0] r_res_tag;
    logic             r_res_illegal;
    logic             r_res_branch;

    alu_op_decode u_decode (
        .i_aluop    (in_aluop),
        .i_funct3   (in_funct3),
        .i_funct7b5 (in_funct7b5),
        .i_use_imm  (in_use_imm),
        .o_op_sel   (w_op_sel),
        .o_illegal  (w_illegal)
    );

    // Handshake control: W frees when empty or draining; E may refill whenever it advances.
    always_comb begin
        w_free   = !r_res_valid || res_ready;
        w_e_adv  = r_e_valid && w_free;
        in_ready = !r_e_valid || w_free;
        w_accept = in_valid && in_ready;
    end

    // Assemble the payload for an op being accepted this cycle.
    always_comb begin
        w_e_next         = '0;
        w_e_next.src1    = in_rs1;
        w_e_next.src2    = in_use_imm ? in_imm : in_rs2;
        w_e_next.op_sel  = w_op_sel;
        w_e_next.tag     = in_tag;
        w_e_next.illegal = w_illegal;
        w_e_next.branch  = (in_aluop == ALUOP_BR);
    end

    // E stage: load on accept, otherwise hold payload so ALU inputs stay stable.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_e       <= '0;
            r_e_valid <= 1'b0;
        end else if (w_accept) begin
            r_e       <= w_e_next;
            r_e_valid <= 1'b1;
        end else if (w_e_adv) begin
            r_e_valid <= 1'b0;
        end
    end

    // W stage: capture ALU output when E advances; fields hold until overwritten.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_res_valid   <= 1'b0;
            r_res_data    <= '0;
            r_res_zero    <= 1'b0;
            r_res_tag     <= '0;
            r_res_illegal <= 1'b0;
            r_res_branch  <= 1'b0;
        end else if (w_e_adv) begin
            r_res_valid   <= 1'b1;
            r_res_data    <= alu_result;
            r_res_zero    <= alu_zero;
            r_res_tag     <= r_e.tag;
            r_res_illegal <= r_e.illegal;
            r_res_branch  <= r_e.branch;
        end else if (res_ready) begin
            r_res_valid   <= 1'b0;
        end
    end

    // Drive registered state onto the ALU and result interfaces.
    always_comb begin
        alu_src1    = r_e.src1;
        alu_src2    = r_e.src2;
        alu_op_sel  = r_e.op_sel;
        res_valid   = r_res_valid;
        res_data    = r_res_data;
        res_zero    = r_res_zero;
        res_tag     = r_res_tag;
        res_illegal = r_res_illegal;
        res_branch  = r_res_branch;
    end

endmodule
